// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, multi-cycle busy hold, bus hold and jump flush/redirect.
// Optional performance counters are enabled by defining CTRL_PERF_EN.
module pipe_hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES      = 1,
   parameter int unsigned LOAD_STALL_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic        ex_is_load_i,
   input  logic        ex_reg_we_i,
   input  logic [4:0]  ex_reg_waddr_i,
   input  logic        id_reg1_re_i,
   input  logic        id_reg2_re_i,
   input  logic [4:0]  id_reg1_raddr_i,
   input  logic [4:0]  id_reg2_raddr_i,
   input  logic        ex_busy_i,
   input  logic        bus_hold_i,
   output logic [2:0]  hold_flag_o,
   output logic        stall_o,
   output logic        jump_ctrl_o,
   output logic        jump_o,
   output logic [31:0] jump_addr_o,
   output logic [1:0]  state_o
`ifdef CTRL_PERF_EN
   ,
   output logic [31:0] perf_stall_cnt_o,
   output logic [31:0] perf_flush_cnt_o
`endif
);

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StFlush  = 2'd1,
      StLstall = 2'd2,
      StBusy   = 2'd3
   } state_e;

   localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);
   localparam logic [2:0] StallLoad = 3'(LOAD_STALL_CYCLES - 1);

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        pend_q, pend_d;
   logic [31:0] pend_addr_q, pend_addr_d;

   logic        hz;
   logic        take_jump;
   logic [31:0] jump_tgt;
   logic [2:0]  hold_c;
   logic        stall_c;
   logic        jctrl_c;
   logic        jump_c;
   logic [31:0] jaddr_c;

   assign hz = ex_is_load_i & ex_reg_we_i & (ex_reg_waddr_i != 5'd0) &
               ((id_reg1_re_i & (id_reg1_raddr_i == ex_reg_waddr_i)) |
                (id_reg2_re_i & (id_reg2_raddr_i == ex_reg_waddr_i)));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      take_jump   = 1'b0;
      jump_tgt    = jump_addr_i;
      hold_c      = 3'd0;
      stall_c     = 1'b0;
      jctrl_c     = 1'b0;
      jump_c      = 1'b0;
      jaddr_c     = 32'd0;

      unique case (state_q)
         StRun: begin
            if (jump_flag_i) begin
               take_jump = 1'b1;
            end else if (ex_busy_i) begin
               hold_c  = 3'd3;
               state_d = StBusy;
               pend_d  = 1'b0;
            end else if (bus_hold_i) begin
               hold_c = 3'd1;
            end else if (hz) begin
               stall_c = 1'b1;
               hold_c  = 3'd2;
               if (LOAD_STALL_CYCLES > 1) begin
                  state_d = StLstall;
                  cnt_d   = StallLoad;
               end
            end
         end
         StFlush: begin
            // EX holds a flushed instruction, so its jump/busy/hazard status is ignored.
            jctrl_c = 1'b1;
            cnt_d   = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
               state_d = StRun;
               cnt_d   = 3'd0;
            end
         end
         StLstall: begin
            if (jump_flag_i) begin
               take_jump = 1'b1;
            end else begin
               // A bus hold (1) never exceeds the stall hold (2).
               stall_c = 1'b1;
               hold_c  = 3'd2;
               cnt_d   = cnt_q - 3'd1;
               if (cnt_q <= 3'd1) begin
                  state_d = StRun;
                  cnt_d   = 3'd0;
               end
            end
         end
         StBusy: begin
            if (ex_busy_i) begin
               hold_c = 3'd3;
               if (jump_flag_i && !pend_q) begin
                  pend_d      = 1'b1;
                  pend_addr_d = jump_addr_i;
               end
            end else if (pend_q) begin
               take_jump = 1'b1;
               jump_tgt  = pend_addr_q;
            end else begin
               state_d = StRun;
               hold_c  = bus_hold_i ? 3'd1 : 3'd0;
            end
         end
      endcase

      if (take_jump) begin
         jump_c      = 1'b1;
         jctrl_c     = 1'b1;
         jaddr_c     = jump_tgt;
         hold_c      = 3'd0;
         stall_c     = 1'b0;
         pend_d      = 1'b0;
         pend_addr_d = 32'd0;
         if (FLUSH_CYCLES > 1) begin
            state_d = StFlush;
            cnt_d   = FlushLoad;
         end else begin
            state_d = StRun;
            cnt_d   = 3'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StRun;
         cnt_q       <= 3'd0;
         pend_q      <= 1'b0;
         pend_addr_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
      end
   end

   // Outputs are forced low for the whole time reset is asserted, not just after the edge.
   assign hold_flag_o = rst ? hold_c  : 3'd0;
   assign stall_o     = rst ? stall_c : 1'b0;
   assign jump_ctrl_o = rst ? jctrl_c : 1'b0;
   assign jump_o      = rst ? jump_c  : 1'b0;
   assign jump_addr_o = rst ? jaddr_c : 32'd0;
   assign state_o     = rst ? state_q : 2'd0;

`ifdef CTRL_PERF_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_flush_q, perf_flush_d;

   always_comb begin
      perf_stall_d = perf_stall_q + (stall_o ? 32'd1 : 32'd0);
      perf_flush_d = perf_flush_q + (jump_o  ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_q <= 32'd0;
         perf_flush_q <= 32'd0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
      end
   end

   assign perf_stall_cnt_o = perf_stall_q;
   assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule
